mem_dump_engine: RTL and testbench
==================================

MEM_DUMP_ENGINE -- requirements
Module: mem_dump_engine

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit data-memory words to dump.
REQ-002 Parameter AW, default 10, word-address width; SHALL satisfy 2**AW >= DEPTH.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 start  input  1  request to begin a dump, sampled on the rising edge of clock.
REQ-006 mem_addr  output  AW  word address to the data-memory read port.
REQ-007 mem_rdata  input  32  read data, valid exactly one cycle after mem_addr is presented.
REQ-008 out_valid  output  1  output beat valid.
REQ-009 out_ready  input  1  consumer accepts the beat.
REQ-010 out_addr  output  32  byte address of the beat (word index * 4).
REQ-011 out_data  output  32  memory word for the beat.
REQ-012 busy  output  1  high from the accepted start until the final beat is accepted.
REQ-013 done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-014 FSM states SHALL be IDLE, READ, CAPTURE, SEND and FIN.
- IDLE->READ on start.
- READ->CAPTURE unconditionally.
- CAPTURE->SEND unconditionally.
- SEND->READ on handshake when index < DEPTH-1.
- SEND->FIN on handshake at the last beat.
- FIN->IDLE unconditionally.
REQ-015 Handshake SHALL be out_valid && out_ready on a rising clock edge.
REQ-016 mem_addr SHALL equal the current index in READ; the word SHALL be registered in CAPTURE.
REQ-017 out_valid SHALL be high only in SEND.
REQ-018 out_addr and out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 out_addr SHALL equal {index, 2'b00} zero-extended to 32 bits.
REQ-020 With no backpressure, consecutive beats SHALL issue every 3 cycles; the first beat SHALL be valid 3 cycles after start is sampled.
REQ-021 The index SHALL run 0..DEPTH-1 with no wrap; after DEPTH-1 the block SHALL enter FIN and never re-read index 0 within the same dump.
REQ-022 start SHALL be ignored while busy=1, including during FIN.
REQ-023 done SHALL be high only in FIN; busy SHALL be low in IDLE and FIN.
REQ-024 If start is high in the same cycle FIN exits, it SHALL be ignored; start SHALL be sampled again only from IDLE.

Reset
REQ-025 On reset=0 the block SHALL asynchronously enter IDLE.
REQ-026 On reset=0: index=0, mem_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0.
REQ-027 Reset mid-dump SHALL abort the dump without a done pulse; a new start after reset release SHALL restart at index 0.

Configuration
REQ-028 Macro DUMP_CHECKSUM_EN: when defined, after beat DEPTH-1 an extra SEND beat SHALL carry out_addr = DEPTH*4 and out_data = XOR of all DEPTH words.
REQ-029 When DUMP_CHECKSUM_EN is defined, done SHALL follow acceptance of the checksum beat.
REQ-030 When DUMP_CHECKSUM_EN is defined, the XOR accumulator SHALL clear on start and on reset.
REQ-031 When DUMP_CHECKSUM_EN is undefined, no accumulator SHALL exist and exactly DEPTH beats SHALL be produced.

Structure
REQ-032 The FSM state encoding and beat-address constants SHALL reside in shared package rv_dump_pkg.
REQ-033 The registered output beat and its hold-under-backpressure logic SHALL be sub-module dump_out_stage; all other logic SHALL be flat.

Verification
REQ-034 DEPTH=4, memory {0x11,0x22,0x33,0x44}, out_ready=1, start pulse -> beats (0x0,0x11), (0x4,0x22), (0x8,0x33), (0xC,0x44), 3 cycles apart; single done pulse; busy falls with done.
REQ-035 out_ready=0 for 5 cycles during beat 1 -> out_valid stays 1 and out_addr/out_data hold 0x4/0x22; exactly 4 beats total, no duplicates.
REQ-036 start re-pulsed during beat 2 -> ignored; exactly 4 beats and one done pulse.
REQ-037 reset=0 asserted during beat 2 -> all outputs 0 immediately, no done; after release, a new start yields a beat at out_addr 0x0.
REQ-038 DUMP_CHECKSUM_EN defined, memory as REQ-034 -> fifth beat (0x10, 0x44); done follows acceptance of the fifth beat.
REQ-039 Default DEPTH=1024 with memory[i]=i -> last beat (0xFFC, 0x3FF), then done; no beat with out_addr 0x1000 when DUMP_CHECKSUM_EN is undefined.

Source files
------------

// File: rtl/rv_dump_pkg.sv
// rv_dump_pkg: FSM encoding, beat record and beat-address helper shared by mem_dump_engine
package rv_dump_pkg;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;
    localparam int BEAT_SHIFT = 2;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;
    function automatic logic [31:0] beat_addr(input logic [31:0] index);
        return index << BEAT_SHIFT;
    endfunction
endpackage

// File: rtl/dump_out_stage.sv
// dump_out_stage: registered output beat, held unchanged until the consumer takes it
module dump_out_stage
    import rv_dump_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  load,
    input  logic  ready,
    input  beat_t beat,
    output logic  valid,
    output beat_t q
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            if (load) q <= beat;
            valid <= load || (valid && !ready);
        end
    end
endmodule

// File: rtl/mem_dump_engine.sv
// mem_dump_engine: streams DEPTH words of data memory out as (byte address, data) beats.
// Optional DUMP_CHECKSUM_EN appends one beat carrying the XOR of all words at address DEPTH*4.
module mem_dump_engine
    import rv_dump_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_addr,
    output logic [31:0]   out_data,
    output logic          busy,
    output logic          done
);
    logic [2:0]    state;
    logic [AW-1:0] index;
    logic          hs, last, load, to_fin;
    beat_t         beat, q;
    assign hs   = out_valid && out_ready;
    assign last = index == AW'(DEPTH - 1);
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] acc;
    logic        ck;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            ck  <= 1'b0;
        end else if (state == S_IDLE && start) begin
            acc <= '0;
            ck  <= 1'b0;
        end else begin
            if (state == S_CAPTURE) acc <= acc ^ mem_rdata;
            if (hs && last) ck <= 1'b1;
        end
    end
`endif
    // the checksum beat is reloaded in place on the last data handshake, so SEND stays put
    always_comb begin
        load   = state == S_CAPTURE;
        beat   = '{beat_addr(32'(index)), mem_rdata};
        to_fin = hs && last;
`ifdef DUMP_CHECKSUM_EN
        if (hs && last && !ck) begin
            load = 1'b1;
            beat = '{beat_addr(32'(DEPTH)), acc};
        end
        to_fin = hs && ck;
`endif
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            index <= '0;
        end else begin
            case (state)
                S_IDLE:    if (start) begin
                    state <= S_READ;
                    index <= '0;
                end
                S_READ:    state <= S_CAPTURE;
                S_CAPTURE: state <= S_SEND;
                S_SEND:    if (to_fin) state <= S_FIN;
                    else if (hs && !last) begin
                        state <= S_READ;
                        index <= index + AW'(1);
                    end
                default:   state <= S_IDLE;
            endcase
        end
    end
    dump_out_stage u_out (
        .clock(clock),
        .reset(reset),
        .load (load),
        .ready(out_ready),
        .beat (beat),
        .valid(out_valid),
        .q    (q)
    );
    assign out_addr = q.addr;
    assign out_data = q.data;
    assign mem_addr = index;
    assign busy     = state == S_READ || state == S_CAPTURE || state == S_SEND;
    assign done     = state == S_FIN;
endmodule

// File: tb/tb_mem_dump_engine.sv
// tb_mem_dump_engine: directed checks of mem_dump_engine at DEPTH=4 and the default DEPTH=1024
module tb_mem_dump_engine;
    import rv_dump_pkg::*;
`ifdef DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int NB4 = 4 + CK;
    localparam int NBK = 1024 + CK;
    typedef struct {
        logic        rdy;
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic        b;
        logic        dn;
        logic        cm;
        logic [31:0] ma;
    } vec_t;
    logic clock = 1'b0, reset = 1'b0;
    logic start4 = 1'b0, ready4 = 1'b1, v4, busy4, done4;
    logic [1:0] maddr4;
    logic [31:0] rdata4, a4, dat4;
    logic startk = 1'b0, readyk = 1'b1, vk, busyk, donek;
    logic [9:0] maddrk;
    logic [31:0] rdatak, ak, datk;
    logic [31:0] mem4 [0:3];
    vec_t vec [1:15];
    int errors = 0, checks = 0;
    int w, bk, bad, dseen, seen1000;
    logic [31:0] la, ld;
    always #5 clock = ~clock;
    always @(posedge clock) rdata4 <= mem4[maddr4];
    always @(posedge clock) rdatak <= {22'd0, maddrk};
    mem_dump_engine #(.DEPTH(4), .AW(2)) u4 (
        .clock(clock), .reset(reset), .start(start4), .mem_addr(maddr4), .mem_rdata(rdata4),
        .out_valid(v4), .out_ready(ready4), .out_addr(a4), .out_data(dat4), .busy(busy4), .done(done4)
    );
    mem_dump_engine uk (
        .clock(clock), .reset(reset), .start(startk), .mem_addr(maddrk), .mem_rdata(rdatak),
        .out_valid(vk), .out_ready(readyk), .out_addr(ak), .out_data(datk), .busy(busyk), .done(donek)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    // one full DEPTH=4 dump with optional stall on one beat and optional start re-pulses
    task automatic dump4(input int stall_beat, input bit restart);
        int beats, dones, stall;
        logic [31:0] ed;
        beats = 0; dones = 0; stall = 0;
        start4 = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clock);
            start4 = restart && ((v4 && beats == 2) || done4);
            if (stall > 0 && stall < 5) chk("stall_valid", v4, 1);
            if (v4 && beats == stall_beat && stall < 5) begin
                ready4 = 1'b0;
                stall++;
                chk("stall_addr", a4, beat_addr(32'(beats)));
                chk("stall_data", dat4, mem4[beats[1:0]]);
            end else ready4 = 1'b1;
            if (v4 && ready4) begin
                ed = beats < 4 ? mem4[beats[1:0]] : 32'h44;
                chk("beat_addr", a4, beat_addr(32'(beats)));
                chk("beat_data", dat4, ed);
                beats++;
            end
            if (done4) begin
                dones++;
                chk("done_busy", busy4, 0);
            end
        end
        start4 = 1'b0;
        ready4 = 1'b1;
        chk("beat_count", beats, NB4);
        chk("done_count", dones, 1);
        chk("idle_busy", busy4, 0);
    endtask
    initial begin
        mem4[0] = 32'h11; mem4[1] = 32'h22; mem4[2] = 32'h33; mem4[3] = 32'h44;
        vec[1]  = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b1, 32'd0};
        vec[2]  = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b0, 32'd0};
        vec[3]  = '{1'b1, 1'b1, 32'h0, 32'h11, 1'b1, 1'b0, 1'b0, 32'd0};
        vec[4]  = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b1, 32'd1};
        vec[5]  = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b0, 32'd0};
        vec[6]  = '{1'b1, 1'b1, 32'h4, 32'h22, 1'b1, 1'b0, 1'b0, 32'd0};
        vec[7]  = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b1, 32'd2};
        vec[8]  = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b0, 32'd0};
        vec[9]  = '{1'b1, 1'b1, 32'h8, 32'h33, 1'b1, 1'b0, 1'b0, 32'd0};
        vec[10] = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b1, 32'd3};
        vec[11] = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b0, 32'd0};
        vec[12] = '{1'b1, 1'b1, 32'hC, 32'h44, 1'b1, 1'b0, 1'b0, 32'd0};
`ifdef DUMP_CHECKSUM_EN
        vec[13] = '{1'b1, 1'b1, 32'h10, 32'h44, 1'b1, 1'b0, 1'b0, 32'd0};
        vec[14] = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b0, 1'b1, 1'b0, 32'd0};
`else
        vec[13] = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b0, 1'b1, 1'b0, 32'd0};
        vec[14] = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 1'b0, 32'd0};
`endif
        vec[15] = '{1'b1, 1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 1'b0, 32'd0};
        repeat (2) @(negedge clock);
        chk("rst_valid", v4, 0);
        chk("rst_addr", a4, 0);
        chk("rst_data", dat4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_maddr", 32'(maddr4), 0);
        chk("rstk_valid", vk, 0);
        reset = 1'b1;
        @(negedge clock);
        start4 = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            start4 = 1'b0;
            ready4 = vec[i].rdy;
            chk($sformatf("row%0d_valid", i), v4, vec[i].v);
            chk($sformatf("row%0d_busy", i), busy4, vec[i].b);
            chk($sformatf("row%0d_done", i), done4, vec[i].dn);
            if (vec[i].v) begin
                chk($sformatf("row%0d_addr", i), a4, vec[i].a);
                chk($sformatf("row%0d_data", i), dat4, vec[i].d);
            end
            if (vec[i].cm) chk($sformatf("row%0d_maddr", i), 32'(maddr4), vec[i].ma);
        end
        dump4(1, 1'b0);
        dump4(-1, 1'b1);
        start4 = 1'b1;
        @(negedge clock);
        start4 = 1'b0;
        w = 0;
        while (!(v4 && a4 == 32'h8) && w < 30) begin
            @(negedge clock);
            w++;
        end
        chk("wait_beat2", w < 30, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_valid", v4, 0);
        chk("abort_addr", a4, 0);
        chk("abort_data", dat4, 0);
        chk("abort_busy", busy4, 0);
        chk("abort_done", done4, 0);
        chk("abort_maddr", 32'(maddr4), 0);
        repeat (3) begin
            @(negedge clock);
            chk("abort_nodone", done4, 0);
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("post_nodone", done4, 0);
        end
        start4 = 1'b1;
        @(negedge clock);
        start4 = 1'b0;
        w = 0;
        while (!v4 && w < 10) begin
            @(negedge clock);
            w++;
        end
        chk("restart_wait", w < 10, 1);
        chk("restart_addr", a4, 0);
        chk("restart_data", dat4, 32'h11);
        repeat (20) @(negedge clock);
        startk = 1'b1;
        @(negedge clock);
        startk = 1'b0;
        bk = 0; bad = 0; dseen = 0; seen1000 = 0; la = '0; ld = '0;
        for (int c = 0; c < 3200 && dseen == 0; c++) begin
            @(negedge clock);
            if (vk) begin
                if (ak !== beat_addr(32'(bk)) || datk !== (bk < 1024 ? 32'(bk) : 32'h0)) bad++;
                if (ak == 32'h1000) seen1000++;
                if (bk == 1023) begin
                    la = ak;
                    ld = datk;
                end
                bk++;
            end
            if (donek) dseen = 1;
        end
        chk("big_bad_beats", bad, 0);
        chk("big_beat_count", bk, NBK);
        chk("big_last_addr", la, 32'hFFC);
        chk("big_last_data", ld, 32'h3FF);
        chk("big_done", dseen, 1);
        chk("big_addr1000", seen1000, CK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
